// File: rtl/frv_intc_pkg.sv
// Shared constants for the interrupt controller: trap cause codes, register offsets, FSM states.
// Latency: n/a (definitions only); backpressure: n/a.
package mypackage;

    localparam logic [5:0] CAUSE_NMI = 6'd0;
    localparam logic [5:0] CAUSE_MSI = 6'd3;
    localparam logic [5:0] CAUSE_MTI = 6'd7;
    localparam logic [5:0] CAUSE_MEI = 6'd11;

    localparam logic [31:0] OFS_IE    = 32'h0000_0000;
    localparam logic [31:0] OFS_MODE  = 32'h0000_0004;
    localparam logic [31:0] OFS_PEND  = 32'h0000_0008;
    localparam logic [31:0] OFS_CLAIM = 32'h0000_000C;
    localparam logic [31:0] OFS_LIMIT = 32'h0000_0010;

    typedef enum logic [1:0] {
        TRAP_IDLE = 2'd0,
        TRAP_REQ  = 2'd1,
        TRAP_WAIT = 2'd2
    } trap_state_e;

    typedef struct packed {
        logic nmi;
        logic mei;
        logic msi;
        logic mti;
    } trap_src_t;

    // Fixed priority: NMI > MEI > MSI > MTI.
    function automatic logic [5:0] trap_cause(input trap_src_t src);
        logic [5:0] cause;
        cause = CAUSE_MTI;
        if (src.msi) cause = CAUSE_MSI;
        if (src.mei) cause = CAUSE_MEI;
        if (src.nmi) cause = CAUSE_NMI;
        return cause;
    endfunction

endpackage

// File: rtl/frv_intc_prio.sv
// Lowest-index-first priority encoder over the enabled pending channels.
// Latency: combinational; backpressure: none.
module frv_intc_prio #(
    parameter int NCH = 8
) (
    input  logic [NCH-1:0] req_i,
    output logic           vld_o,
    output logic [4:0]     id_o
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        vld_o = 1'b0;
        id_o  = 5'd0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                vld_o = 1'b1;
                id_o  = 5'(i);
            end
        end
    end

endmodule

// File: rtl/frv_intc.sv
// Machine-mode interrupt controller: MMIO IE/MODE/PEND/CLAIM, mip view, trap request FSM.
// Latency: MMIO reads combinational, state 1 cycle; trap req held until ack (no other backpressure).
module frv_intc
    import mypackage::*;
#(
    parameter int          NCH            = 8,
    parameter logic [31:0] MMIO_BASE_ADDR = 32'h0000_2000,
    parameter logic [31:0] MMIO_BASE_MASK = 32'hFFFF_F000
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            mstatus_mie,
    input  logic            mie_meie,
    input  logic            mie_mtie,
    input  logic            mie_msie,
    input  logic            nmi_pending,
    input  logic            ti_pending,
    input  logic            sw_pending,
    input  logic [NCH-1:0]  ext_irq,
    input  logic            mmio_en,
    input  logic            mmio_wen,
    input  logic [31:0]     mmio_addr,
    input  logic [31:0]     mmio_wdata,
    output logic [31:0]     mmio_rdata,
    output logic            mmio_error,
    output logic            mip_meip,
    output logic            mip_mtip,
    output logic            mip_msip,
    output logic            int_trap_req,
    output logic [5:0]      int_trap_cause,
    input  logic            int_trap_ack
);

    logic [NCH-1:0] ie_q, ie_d;
    logic [NCH-1:0] mode_q, mode_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic [NCH-1:0] ext_prev_q;
    logic           nmi_prev_q;
    logic           nmi_lat_q, nmi_lat_d;
    logic           mip_meip_q, mip_mtip_q, mip_msip_q;
    trap_state_e    state_q, state_d;
    logic [5:0]     cause_q, cause_d;

    // MMIO decode
    logic        win_hit;
    logic [31:0] offset;
    logic        acc_err;
    logic        acc_ok;
    logic        reg_wr;
    logic        reg_rd;

    assign win_hit = ((mmio_addr & MMIO_BASE_MASK) == (MMIO_BASE_ADDR & MMIO_BASE_MASK));
    assign offset  = mmio_addr & ~MMIO_BASE_MASK;
    assign acc_err = mmio_en && win_hit &&
                     ((offset >= OFS_LIMIT) || (mmio_addr[1:0] != 2'b00));
    assign acc_ok  = mmio_en && win_hit && !acc_err;
    assign reg_wr  = acc_ok && mmio_wen;
    assign reg_rd  = acc_ok && !mmio_wen;

    assign mmio_error = acc_err;

    // Claim arbitration
    logic [NCH-1:0] pend_en;
    logic           claim_vld;
    logic [4:0]     claim_id;

    assign pend_en = pend_q & ie_q;

    frv_intc_prio #(
        .NCH (NCH)
    ) u_prio (
        .req_i (pend_en),
        .vld_o (claim_vld),
        .id_o  (claim_id)
    );

    always_comb begin
        mmio_rdata = 32'd0;
        if (acc_ok) begin
            case (offset)
                OFS_IE:    mmio_rdata = 32'(ie_q);
                OFS_MODE:  mmio_rdata = 32'(mode_q);
                OFS_PEND:  mmio_rdata = 32'(pend_q);
                OFS_CLAIM: mmio_rdata = {claim_vld, 26'd0, claim_id};
                default:   mmio_rdata = 32'd0;
            endcase
        end
    end

    // Register file and pending state
    logic [NCH-1:0] edge_set;
    logic [NCH-1:0] w1c;
    logic [NCH-1:0] claim_clr;

    assign edge_set = ext_irq & ~ext_prev_q & mode_q;

    always_comb begin
        ie_d      = ie_q;
        mode_d    = mode_q;
        w1c       = '0;
        claim_clr = '0;
        if (reg_wr && (offset == OFS_IE))   ie_d   = mmio_wdata[NCH-1:0];
        if (reg_wr && (offset == OFS_MODE)) mode_d = mmio_wdata[NCH-1:0];
        if (reg_wr && (offset == OFS_PEND)) w1c    = mmio_wdata[NCH-1:0];
        for (int i = 0; i < NCH; i++) begin
            claim_clr[i] = reg_rd && (offset == OFS_CLAIM) && claim_vld &&
                           (claim_id == 5'(i)) && mode_q[i];
        end
        // Edge channels: a new edge beats any clear landing in the same cycle.
        for (int i = 0; i < NCH; i++) begin
            if (mode_q[i]) begin
                pend_d[i] = (pend_q[i] && !(w1c[i] || claim_clr[i])) || edge_set[i];
            end else begin
                pend_d[i] = ext_irq[i];
            end
        end
    end

    // Trap source qualification and FSM
    trap_src_t src;
    logic      any_src;
    logic      trap_acked;

    always_comb begin
        src.nmi = nmi_lat_q;
        src.mei = mstatus_mie && mie_meie && mip_meip_q;
        src.msi = mstatus_mie && mie_msie && mip_msip_q;
        src.mti = mstatus_mie && mie_mtie && mip_mtip_q;
    end

    assign any_src    = src.nmi || src.mei || src.msi || src.mti;
    assign trap_acked = (state_q == TRAP_REQ) && int_trap_ack;

    always_comb begin
        nmi_lat_d = nmi_lat_q;
        if (trap_acked && (cause_q == CAUSE_NMI)) nmi_lat_d = 1'b0;
        if (nmi_pending && !nmi_prev_q)           nmi_lat_d = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            TRAP_IDLE: begin
                if (any_src) begin
                    cause_d = trap_cause(src);
                    state_d = TRAP_REQ;
                end
            end
            TRAP_REQ: begin
                if (int_trap_ack) state_d = TRAP_WAIT;
            end
            TRAP_WAIT: state_d = TRAP_IDLE;
            default:   state_d = TRAP_IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            ie_q       <= '0;
            mode_q     <= '0;
            pend_q     <= '0;
            ext_prev_q <= '0;
            nmi_prev_q <= 1'b0;
            nmi_lat_q  <= 1'b0;
            mip_meip_q <= 1'b0;
            mip_mtip_q <= 1'b0;
            mip_msip_q <= 1'b0;
            state_q    <= TRAP_IDLE;
            cause_q    <= 6'd0;
        end else begin
            ie_q       <= ie_d;
            mode_q     <= mode_d;
            pend_q     <= pend_d;
            ext_prev_q <= ext_irq;
            nmi_prev_q <= nmi_pending;
            nmi_lat_q  <= nmi_lat_d;
            mip_meip_q <= |pend_en;
            mip_mtip_q <= ti_pending;
            mip_msip_q <= sw_pending;
            state_q    <= state_d;
            cause_q    <= cause_d;
        end
    end

    assign mip_meip       = mip_meip_q;
    assign mip_mtip       = mip_mtip_q;
    assign mip_msip       = mip_msip_q;
    assign int_trap_req   = (state_q == TRAP_REQ);
    assign int_trap_cause = cause_q;

endmodule

// File: tb/tb_frv_intc.sv
// Directed bench for frv_intc: expectations queued at stimulus time, popped at each observation.
module tb_frv_intc;

    localparam logic [31:0] B = 32'h0000_2000;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        mstatus_mie, mie_meie, mie_mtie, mie_msie;
    logic        nmi_pending, ti_pending, sw_pending;
    logic [7:0]  ext_irq;
    logic        mmio_en, mmio_wen;
    logic [31:0] mmio_addr, mmio_wdata, mmio_rdata;
    logic        mmio_error;
    logic        mip_meip, mip_mtip, mip_msip;
    logic        int_trap_req;
    logic [5:0]  int_trap_cause;
    logic        int_trap_ack;

    logic [31:0] exp_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    logic [31:0] rd_d;
    logic        rd_e;

    always #5 g_clk = ~g_clk;

    frv_intc #(
        .NCH            (8),
        .MMIO_BASE_ADDR (32'h0000_2000),
        .MMIO_BASE_MASK (32'hFFFF_F000)
    ) dut (
        .g_clk          (g_clk),
        .g_resetn       (g_resetn),
        .mstatus_mie    (mstatus_mie),
        .mie_meie       (mie_meie),
        .mie_mtie       (mie_mtie),
        .mie_msie       (mie_msie),
        .nmi_pending    (nmi_pending),
        .ti_pending     (ti_pending),
        .sw_pending     (sw_pending),
        .ext_irq        (ext_irq),
        .mmio_en        (mmio_en),
        .mmio_wen       (mmio_wen),
        .mmio_addr      (mmio_addr),
        .mmio_wdata     (mmio_wdata),
        .mmio_rdata     (mmio_rdata),
        .mmio_error     (mmio_error),
        .mip_meip       (mip_meip),
        .mip_mtip       (mip_mtip),
        .mip_msip       (mip_msip),
        .int_trap_req   (int_trap_req),
        .int_trap_cause (int_trap_cause),
        .int_trap_ack   (int_trap_ack)
    );

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        n_chk++;
        if (exp_q.size() == 0) exp = 'x;
        else exp = exp_q.pop_front();
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic mmio_rd(input logic [31:0] a, output logic [31:0] d, output logic e);
        @(negedge g_clk);
        mmio_en   = 1'b1;
        mmio_wen  = 1'b0;
        mmio_addr = a;
        #1;
        d = mmio_rdata;
        e = mmio_error;
        @(posedge g_clk);
        #1;
        mmio_en   = 1'b0;
        mmio_addr = 32'd0;
    endtask

    task automatic mmio_wr(input logic [31:0] a, input logic [31:0] w, output logic e);
        @(negedge g_clk);
        mmio_en    = 1'b1;
        mmio_wen   = 1'b1;
        mmio_addr  = a;
        mmio_wdata = w;
        #1;
        e = mmio_error;
        @(posedge g_clk);
        #1;
        mmio_en    = 1'b0;
        mmio_wen   = 1'b0;
        mmio_addr  = 32'd0;
        mmio_wdata = 32'd0;
    endtask

    task automatic pulse_ack();
        @(negedge g_clk);
        int_trap_ack = 1'b1;
        @(posedge g_clk);
        #1;
        int_trap_ack = 1'b0;
    endtask

    task automatic wait_req(input string tag, input int budget);
        int k;
        k = 0;
        while (!int_trap_req && k < budget) begin
            @(negedge g_clk);
            k++;
        end
        expect_val(32'd1);
        check(tag, {31'd0, int_trap_req});
    endtask

    initial begin
        g_resetn     = 1'b0;
        mstatus_mie  = 1'b0;
        mie_meie     = 1'b0;
        mie_mtie     = 1'b0;
        mie_msie     = 1'b0;
        nmi_pending  = 1'b0;
        ti_pending   = 1'b1;
        sw_pending   = 1'b1;
        ext_irq      = 8'h00;
        mmio_en      = 1'b0;
        mmio_wen     = 1'b0;
        mmio_addr    = B + 32'hC;
        mmio_wdata   = 32'd0;
        int_trap_ack = 1'b0;

        // Reset state, with mip sources held high
        repeat (2) @(negedge g_clk);
        expect_val(32'd0); check("rst_req", {31'd0, int_trap_req});
        expect_val(32'd0); check("rst_cause", 32'(int_trap_cause));
        expect_val(32'd0); check("rst_mtip", {31'd0, mip_mtip});
        expect_val(32'd0); check("rst_msip", {31'd0, mip_msip});
        expect_val(32'd0); check("rdata_en0", mmio_rdata);
        ti_pending = 1'b0;
        sw_pending = 1'b0;
        mmio_addr  = 32'd0;
        g_resetn   = 1'b1;

        // Register setup and readback
        mmio_wr(B + 32'h0, 32'hFFFF_FF05, rd_e);
        mmio_wr(B + 32'h4, 32'h0000_0001, rd_e);
        expect_val(32'h05); mmio_rd(B + 32'h0, rd_d, rd_e); check("ie_rd", rd_d);
        expect_val(32'h01); mmio_rd(B + 32'h4, rd_d, rd_e); check("mode_rd", rd_d);

        // Edge pulse on ch0, then claim
        @(negedge g_clk); ext_irq[0] = 1'b1;
        @(negedge g_clk); ext_irq[0] = 1'b0;
        @(negedge g_clk);
        expect_val(32'd1); check("meip_set", {31'd0, mip_meip});
        expect_val(32'h01); mmio_rd(B + 32'h8, rd_d, rd_e); check("pend_edge", rd_d);
        expect_val(32'h8000_0000); mmio_rd(B + 32'hC, rd_d, rd_e); check("claim_ch0", rd_d);
        expect_val(32'h00); mmio_rd(B + 32'h8, rd_d, rd_e); check("pend_after_claim", rd_d);
        expect_val(32'h00); mmio_rd(B + 32'hC, rd_d, rd_e); check("claim_empty", rd_d);
        repeat (2) @(negedge g_clk);
        expect_val(32'd0); check("meip_clr", {31'd0, mip_meip});

        // Level channel 2: follows the line, W1C and claim have no effect
        @(negedge g_clk); ext_irq[2] = 1'b1;
        expect_val(32'h04); mmio_rd(B + 32'h8, rd_d, rd_e); check("pend_level", rd_d);
        mmio_wr(B + 32'h8, 32'h04, rd_e);
        expect_val(32'h04); mmio_rd(B + 32'h8, rd_d, rd_e); check("pend_level_w1c", rd_d);
        expect_val(32'h8000_0002); mmio_rd(B + 32'hC, rd_d, rd_e); check("claim_ch2", rd_d);
        expect_val(32'h04); mmio_rd(B + 32'h8, rd_d, rd_e); check("pend_level_claim", rd_d);
        @(negedge g_clk); ext_irq[2] = 1'b0;
        expect_val(32'h00); mmio_rd(B + 32'h8, rd_d, rd_e); check("pend_level_drop", rd_d);

        // Bad accesses
        expect_val(32'd1); mmio_wr(B + 32'h10, 32'hFF, rd_e); check("err_wr_0x10", {31'd0, rd_e});
        expect_val(32'd1); mmio_wr(B + 32'h1, 32'hFF, rd_e); check("err_wr_0x1", {31'd0, rd_e});
        expect_val(32'd1); mmio_rd(B + 32'h6, rd_d, rd_e); check("err_rd_0x6", {31'd0, rd_e});
        expect_val(32'h05); mmio_rd(B + 32'h0, rd_d, rd_e); check("ie_unchanged", rd_d);
        expect_val(32'h01); mmio_rd(B + 32'h4, rd_d, rd_e); check("mode_unchanged", rd_d);
        expect_val(32'd0); mmio_rd(32'h0000_3000, rd_d, rd_e); check("outside_err", {31'd0, rd_e});
        expect_val(32'd0); check("outside_rdata", rd_d);

        // Edge set beats W1C in the same cycle on ch3
        mmio_wr(B + 32'h4, 32'h09, rd_e);
        @(negedge g_clk);
        ext_irq[3] = 1'b1;
        mmio_en    = 1'b1;
        mmio_wen   = 1'b1;
        mmio_addr  = B + 32'h8;
        mmio_wdata = 32'h08;
        @(posedge g_clk);
        #1;
        mmio_en  = 1'b0;
        mmio_wen = 1'b0;
        expect_val(32'h08); mmio_rd(B + 32'h8, rd_d, rd_e); check("set_beats_w1c", rd_d);
        mmio_wr(B + 32'h8, 32'h08, rd_e);
        expect_val(32'h00); mmio_rd(B + 32'h8, rd_d, rd_e); check("w1c_edge", rd_d);
        @(negedge g_clk); ext_irq[3] = 1'b0;

        // MEI over MSI, then MSI after ack and the enforced gap
        mmio_wr(B + 32'h4, 32'h01, rd_e);
        @(negedge g_clk);
        ext_irq[2] = 1'b1;
        sw_pending = 1'b1;
        repeat (3) @(negedge g_clk);
        expect_val(32'd1); check("msip_view", {31'd0, mip_msip});
        expect_val(32'd0); check("no_trap_mie0", {31'd0, int_trap_req});
        mstatus_mie = 1'b1;
        mie_meie    = 1'b1;
        mie_msie    = 1'b1;
        wait_req("mei_req", 10);
        expect_val(32'd11); check("mei_cause", 32'(int_trap_cause));
        mie_meie   = 1'b0;
        ext_irq[2] = 1'b0;
        repeat (2) @(negedge g_clk);
        expect_val(32'd1);  check("mei_hold_req", {31'd0, int_trap_req});
        expect_val(32'd11); check("mei_hold_cause", 32'(int_trap_cause));
        pulse_ack();
        @(negedge g_clk);
        expect_val(32'd0); check("gap1", {31'd0, int_trap_req});
        @(negedge g_clk);
        expect_val(32'd0); check("gap2", {31'd0, int_trap_req});
        @(negedge g_clk);
        expect_val(32'd1); check("msi_req", {31'd0, int_trap_req});
        expect_val(32'd3); check("msi_cause", 32'(int_trap_cause));
        @(negedge g_clk);
        mie_msie    = 1'b0;
        sw_pending  = 1'b0;
        mstatus_mie = 1'b0;
        pulse_ack();
        repeat (3) @(negedge g_clk);
        expect_val(32'd0); check("msi_done", {31'd0, int_trap_req});

        // NMI with mstatus_mie=0, held without ack
        @(negedge g_clk); nmi_pending = 1'b1;
        wait_req("nmi_req", 10);
        expect_val(32'd0); check("nmi_cause", 32'(int_trap_cause));
        nmi_pending = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge g_clk);
            expect_val(32'd1); check($sformatf("nmi_hold%0d", i), {31'd0, int_trap_req});
        end
        pulse_ack();
        repeat (3) @(negedge g_clk);
        expect_val(32'd0); check("nmi_cleared", {31'd0, int_trap_req});

        // Reset while a request is outstanding
        @(negedge g_clk); nmi_pending = 1'b1;
        wait_req("nmi_req2", 10);
        nmi_pending = 1'b0;
        ext_irq[0]  = 1'b1;
        @(negedge g_clk); ext_irq[0] = 1'b0;
        expect_val(32'h01); mmio_rd(B + 32'h8, rd_d, rd_e); check("pend_pre_rst", rd_d);
        @(negedge g_clk); g_resetn = 1'b0;
        @(negedge g_clk);
        expect_val(32'd0); check("rst_req_drop", {31'd0, int_trap_req});
        expect_val(32'd0); check("rst_cause_drop", 32'(int_trap_cause));
        expect_val(32'h00); mmio_rd(B + 32'h8, rd_d, rd_e); check("rst_pend", rd_d);
        expect_val(32'h00); mmio_rd(B + 32'h0, rd_d, rd_e); check("rst_ie", rd_d);
        @(negedge g_clk); g_resetn = 1'b1;
        repeat (3) @(negedge g_clk);
        expect_val(32'd0); check("post_rst_idle", {31'd0, int_trap_req});
        expect_val(32'd0); check("post_rst_meip", {31'd0, mip_meip});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
